// File: rtl/hello_pkg.sv
// hello_pkg: shared types, character codes and the default message for the hello streamer.
package hello_pkg;

    typedef enum logic [1:0] {
        ONCE_FWD = 2'b00,
        LOOP_FWD = 2'b01,
        ONCE_REV = 2'b10,
        LOOP_REV = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CODE_W      = 5;
    localparam int DEF_MSG_LEN = 10;

    localparam logic [CODE_W-1:0] CH_D = 5'd4;
    localparam logic [CODE_W-1:0] CH_E = 5'd5;
    localparam logic [CODE_W-1:0] CH_H = 5'd8;
    localparam logic [CODE_W-1:0] CH_L = 5'd12;
    localparam logic [CODE_W-1:0] CH_O = 5'd15;
    localparam logic [CODE_W-1:0] CH_R = 5'd18;
    localparam logic [CODE_W-1:0] CH_W = 5'd23;

    localparam logic [CODE_W-1:0] DEF_MSG [DEF_MSG_LEN] = '{
        CH_H, CH_E, CH_L, CH_L, CH_O, CH_W, CH_O, CH_R, CH_L, CH_D
    };

    // Positions past the stored message read as blank (code 0).
    function automatic logic [CODE_W-1:0] msg_code(input logic [31:0] i);
        return (i < 32'(DEF_MSG_LEN)) ? DEF_MSG[i[3:0]] : '0;
    endfunction

endpackage

// File: rtl/hello_msg_rom.sv
// hello_msg_rom: combinational message lookup, index to zero-extended character code.
import hello_pkg::*;

module hello_msg_rom #(
    parameter int MSG_LEN = 10,
    parameter int DATA_W  = 6,
    parameter int IDX_W   = $clog2(MSG_LEN)
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [DATA_W-1:0] o_char
);

    assign o_char = DATA_W'(msg_code(32'(i_idx)));

endmodule

// File: rtl/hello_stream_gen.sv
// hello_stream_gen: plays the ROM message over valid/ready in once/loop, forward/reverse modes.
// All outputs are registered; global_reset clears them asynchronously.
import hello_pkg::*;

module hello_stream_gen #(
    parameter int DATA_W  = 6,
    parameter int MSG_LEN = 10,
    parameter int IDX_W   = $clog2(MSG_LEN)
) (
    input  logic              bertaClock,
    input  logic              global_reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z,
    output logic              z_valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);

    state_t            r_state, w_state_nxt;
    mode_t             r_mode;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_step;
    logic [DATA_W-1:0] r_z, w_z_nxt, w_rom_char;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_go, w_fwd, w_loop, w_last, w_xfer;

    assign w_go   = start & ~abort;
    assign w_fwd  = ~r_mode[1];
    assign w_loop = r_mode[0];
    assign w_xfer = r_valid & out_ready;
    assign w_last = w_fwd ? (r_idx == LAST) : (r_idx == '0);

    // Wrap by explicit compare so non-power-of-two lengths stay in range.
    assign w_idx_step = w_fwd ? (w_last ? '0 : r_idx + 1'b1)
                              : (w_last ? LAST : r_idx - 1'b1);

    hello_msg_rom #(
        .MSG_LEN (MSG_LEN),
        .DATA_W  (DATA_W)
    ) u_rom (
        .i_idx  (w_idx_nxt),
        .o_char (w_rom_char)
    );

    always_ff @(posedge bertaClock or posedge global_reset) begin
        if (global_reset) begin
            r_state <= IDLE;
            r_mode  <= ONCE_FWD;
            r_idx   <= '0;
            r_z     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= (r_state == IDLE && w_go) ? mode_t'(mode) : r_mode;
            r_idx   <= w_idx_nxt;
            r_z     <= w_z_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_go ? RUN : IDLE;
            RUN:     w_state_nxt = abort ? IDLE
                                 : (w_xfer && w_last && !w_loop) ? DONE : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next output values; the ROM is addressed with the next index so z is registered.
    always_comb begin
        w_valid_nxt = (w_state_nxt == RUN);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_done_nxt  = (w_state_nxt == DONE);
        w_idx_nxt   = '0;
        if (w_valid_nxt)
            w_idx_nxt = (r_state == IDLE) ? (mode[1] ? LAST : '0)
                                          : (w_xfer ? w_idx_step : r_idx);
        w_z_nxt     = w_valid_nxt ? w_rom_char : '0;
    end

    assign z       = r_z;
    assign z_valid = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign idx     = r_idx;

endmodule

// File: tb/tb_hello_stream_gen.sv
// tb_hello_stream_gen: transfer-count reference model checked every cycle, plus literal sequence pins.
module tb_hello_stream_gen;

    localparam int DW = 6;
    localparam int L  = 10;
    localparam int IW = $clog2(L);

    logic          bertaClock = 1'b0;
    logic          global_reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] z;
    logic          z_valid, busy, done;
    logic [IW-1:0] idx;

    int checks = 0;
    int errors = 0;

    int exp_fwd [10] = '{8, 5, 12, 12, 15, 23, 15, 18, 12, 4};
    int exp_rev [10] = '{4, 12, 18, 15, 23, 15, 12, 12, 5, 8};

    always #5 bertaClock = ~bertaClock;

    hello_stream_gen #(.DATA_W(DW), .MSG_LEN(L)) dut (
        .bertaClock   (bertaClock),
        .global_reset (global_reset),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .out_ready    (out_ready),
        .z            (z),
        .z_valid      (z_valid),
        .busy         (busy),
        .done         (done),
        .idx          (idx)
    );

    // Model: playback is "k characters delivered so far" in a latched mode.
    bit         m_play  = 1'b0;
    bit         m_pulse = 1'b0;
    int         m_k     = 0;
    logic [1:0] m_mode  = 2'b00;

    function automatic int msg(input int i);
        string s = "HELLOWORLD";
        return (i < 10) ? int'(s[i]) - 64 : 0;
    endfunction

    function automatic int m_pos();
        int r = m_k % L;
        return m_mode[1] ? L - 1 - r : r;
    endfunction

    always @(posedge bertaClock or posedge global_reset) begin
        if (global_reset) begin
            m_play  <= 1'b0;
            m_pulse <= 1'b0;
            m_k     <= 0;
        end else if (m_pulse) begin
            m_pulse <= 1'b0;
        end else if (m_play) begin
            if (abort) m_play <= 1'b0;
            else if (out_ready) begin
                m_k <= m_k + 1;
                if (!m_mode[0] && m_k + 1 == L) begin
                    m_play  <= 1'b0;
                    m_pulse <= 1'b1;
                end
            end
        end else if (start && !abort) begin
            m_play <= 1'b1;
            m_k    <= 0;
            m_mode <= mode;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("model_z_valid", 32'(z_valid), 32'(m_play));
        check("model_z", 32'(z), m_play ? msg(m_pos()) : 0);
        check("model_idx", 32'(idx), m_play ? m_pos() : 0);
        check("model_busy", 32'(busy), 32'(m_play | m_pulse));
        check("model_done", 32'(done), 32'(m_pulse));
    endtask

    task automatic step();
        @(negedge bertaClock);
        compare();
    endtask

    task automatic play_once(input logic [1:0] md, input int exp [10], input string nm, input int hold);
        int got[$];
        mode      = md;
        start     = 1'b1;
        out_ready = (hold == 0);
        step();
        start = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check({nm, "_hold_z"}, 32'(z), exp[0]);
            check({nm, "_hold_idx"}, 32'(idx), md[1] ? L - 1 : 0);
            step();
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            if (z_valid) got.push_back(int'(z));
            step();
        end
        check({nm, "_len"}, got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            check({nm, "_seq"}, got[i], exp[i]);
        check({nm, "_done"}, 32'(done), 1);
        check({nm, "_valid_end"}, 32'(z_valid), 0);
        step();
        check({nm, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int prev, wraps;
        repeat (2) step();
        check("rst_z", 32'(z), 0);
        check("rst_valid", 32'(z_valid), 0);
        check("rst_busy", 32'(busy), 0);
        global_reset = 1'b0;
        step();

        play_once(2'b00, exp_fwd, "once_fwd", 0);
        play_once(2'b00, exp_fwd, "backpressure", 3);
        play_once(2'b10, exp_rev, "once_rev", 0);

        mode = 2'b01; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; prev = -1; wraps = 0;
        for (int n = 0; n < 25; n++) begin
            start = (n == 12);
            if (prev == 4) begin
                check("loop_wrap", 32'(z), 8);
                wraps++;
            end
            check("loop_done", 32'(done), 0);
            check("loop_busy", 32'(busy), 1);
            prev = int'(z);
            step();
        end
        check("loop_wrapped", 32'(wraps > 0), 1);
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check("loop_abort_valid", 32'(z_valid), 0);

        mode = 2'b00; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 10 && idx != 4; n++) step();
        check("abort_at_z", 32'(z), 15);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", 32'(z_valid), 0);
        check("abort_busy", 32'(busy), 0);
        for (int n = 0; n < 12; n++) begin
            check("abort_no_done", 32'(done), 0);
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_z", 32'(z), 8);

        mode = 2'b01;
        repeat (3) step();
        #2 global_reset = 1'b1;
        #1;
        check("async_rst_z", 32'(z), 0);
        check("async_rst_valid", 32'(z_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge bertaClock);
        global_reset = 1'b0;
        compare();

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_valid", 32'(z_valid), 0);
        check("start_abort_busy", 32'(busy), 0);
        step();

        for (int n = 0; n < 800; n++) begin
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hello_stream_gen.md
# hello_stream_gen

Parametrised message streamer, the next generation of the HelloWorld character generator. It plays a fixed message from an internal ROM one character per transfer over a valid/ready output interface. Message length and character width are parameters. It adds loop and reverse playback modes, backpressure and abort, none of which the first generation had. It sits between the board input pads and the character output drivers.

## Interface
- DATA_W, 6: character width in bits; the codes below need DATA_W ≥ 5.
- MSG_LEN, 10: message length in characters, ≥ 2.
- IDX_W, $clog2(MSG_LEN): index width, derived; do not override.

Ports:
- bertaClock  in  1  single clock, rising-edge.
- global_reset  in  1  asynchronous, active-high reset.
- start  in  1  begin playback; sampled only in IDLE.
- mode  in  2  00 once-forward, 01 loop-forward, 10 once-reverse, 11 loop-reverse; latched on accepted start.
- abort  in  1  stop playback; priority over everything except reset.
- out_ready  in  1  downstream accepts z this cycle.
- z  out  DATA_W  current character.
- z_valid  out  1  z holds a valid character.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last character of a once-mode pass.
- idx  out  IDX_W  ROM index of the current z.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- In IDLE, z=0, z_valid=0, busy=0, done=0, idx=0.
- IDLE→RUN on start=1 and abort=0.
  - Latch mode.
  - Set idx=0 for forward or MSG_LEN-1 for reverse.
  - Register z=ROM[idx] and set z_valid=1.
- In RUN, a transfer is z_valid & out_ready.
  - On a transfer, idx advances by +1 (forward) or −1 (reverse) and z is updated to ROM[new idx].
  - Without a transfer, z and idx hold and z_valid stays 1.
- Last character transferred:
  - Last means idx=MSG_LEN-1 (forward) or idx=0 (reverse).
  - In a loop mode, idx wraps to 0 (forward) or MSG_LEN-1 (reverse) with no gap cycle, and done is never asserted.
  - In a once mode, go to DONE with z_valid=0 and z=0. DONE asserts done=1 for exactly one cycle, then goes to IDLE.
- abort=1 in RUN or DONE: go to IDLE on the next edge with z_valid=0 and done=0. Any in-flight character is dropped.
- start in RUN or DONE is ignored. Changes to mode after start are ignored.
- start and abort high in the same IDLE cycle: stay in IDLE.
- Message ROM, encoding A=1…Z=26: "HELLOWORLD" = 8,5,12,12,15,23,15,18,12,4.
  - If MSG_LEN > 10, entries 10.. hold 0.
  - If MSG_LEN < 10, the message is truncated.
- Width rules:
  - z is zero-extended from the 5-bit code.
  - idx arithmetic is modulo MSG_LEN via explicit wrap compares, never by natural overflow.

## Timing
- Every output is registered. No combinational path from any input to any output.
- Start latency: start sampled at edge t gives z_valid=1 and z=first character after edge t.
- Throughput: one character per cycle while out_ready=1.
- Backpressure: z, idx and z_valid are stable while z_valid & !out_ready.
- Once-mode end: last transfer at edge t; after edge t, z_valid=0 and done=1; after edge t+1, IDLE. A new start is accepted from edge t+2.
- Abort latency: one edge.
- global_reset asserted at any time, including mid-transfer: all outputs go to their IDLE values immediately, without waiting for a clock edge. Deassertion is synchronised by the board reset tree.

## Structure
- Shared package hello_pkg holds:
  - mode_t enum: ONCE_FWD, LOOP_FWD, ONCE_REV, LOOP_REV.
  - state_t enum: IDLE, RUN, DONE.
  - Character-code constants and the default message constant array of 5-bit codes.
- One sub-module, hello_msg_rom:
  - Parameters MSG_LEN and DATA_W.
  - Combinational lookup idx → char, zero-extended.
  - The top registers its output into z.
- The top holds the FSM, the index counter and the output register. Target size is about 150–250 lines.

## Test plan
- Once-forward, out_ready=1 held, start pulsed:
  - z=8,5,12,12,15,23,15,18,12,4 on 10 consecutive cycles with z_valid=1.
  - Next cycle: done=1 and z_valid=0. Following cycle: busy=0.
- Backpressure: out_ready=0 for 3 cycles after the first character. z stays 8 and idx stays 0 for those 3 cycles, then the sequence resumes with 5 and no character is lost or duplicated.
- Once-reverse: z=4,12,18,15,23,15,12,12,5,8, then the done pulse.
- Loop-forward, 25 cycles with out_ready=1:
  - After 4 comes 8 in the next cycle.
  - done stays 0 and busy stays 1 throughout.
  - A start pulse mid-run has no effect.
- Abort while z=15 (idx 4): z_valid=0 and busy=0 after one edge, done never pulses. A fresh start then begins at 8.
- Asynchronous reset:
  - global_reset raised between clock edges mid-run: z=0, z_valid=0 and busy=0 before the next edge.
  - Start together with abort in IDLE: no playback.
